dmem_access_arbiter: RTL and testbench

//  Owns the single write/read port of the 16x8 data memory and shares it between the i281 CPU,
//  a debug/loader port (REQ/GNT/ACK) and a clear sequencer that zero-fills the memory.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_starve_counter.sv | 43 ++++
 rtl/dmem_access_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_access_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and default sizes for the data-memory access
//               arbiter. It holds the arbiter state encoding and the default
//               data, address and starvation-limit values.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int ADDR_W_DEF       = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBG   = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_starve_counter
// Description : Saturating up-counter. It counts the cycles that a pending
//               debug request has lost the memory port to CPU writes.
//               Clear has priority over increment. With neither asserted,
//               the count holds.
// Ports       : clk, rst (async, active-high)
//               inc      - count one more starved cycle
//               clr      - return the count to zero
//               at_limit - count has reached LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  assign at_limit = (count == CNT_W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_arbiter
// Description : Owns the single write/read port of the data memory. It shares
//               that port between three users:
//                 - the CPU,
//                 - a debug/loader port using a REQ/GNT/ACK handshake,
//                 - a clear sequencer that zero-fills the memory.
//               The CPU is stalled whenever the port is lent out. A
//               starvation counter bounds how long a debug request waits
//               behind CPU writes.
// Ports       : Clock, Reset (async, active-high)
//               CPU_*        - CPU write/read request, CPU_STALL back
//               DBG_*        - debug REQ/WE/ADDR/WDATA in, GNT/ACK/RDATA out
//               CLR_*        - clear start in, BUSY/DONE out
//               Write_Enable, WRITE_SELECT, READ_SELECT, DMEM_INPUT -> DMEM
//               DMEM_OUTPUT  <- DMEM (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                DATA_W       = DATA_W_DEF,
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter int                DEPTH        = 2 ** ADDR_W,
  parameter int                STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_WRITE_SELECT,
  input  logic [ADDR_W-1:0] CPU_READ_SELECT,
  input  logic [DATA_W-1:0] CPU_DATA,
  output logic              CPU_STALL,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic              DBG_GNT,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_RDATA,
  input  logic              CLR_START,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  output logic              Write_Enable,
  output logic [ADDR_W-1:0] WRITE_SELECT,
  output logic [ADDR_W-1:0] READ_SELECT,
  output logic [DATA_W-1:0] DMEM_INPUT,
  input  logic [DATA_W-1:0] DMEM_OUTPUT
);

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              ack_q;
  logic              clr_done_q;
  logic              stall_q;
  logic              gnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;

  logic at_limit;
  logic go_clear;
  logic go_dbg;
  logic starve_inc;
  logic starve_clr;
  logic we_mux;

  // A clear outranks a debug grant in the same cycle. While ack_q is high,
  // no new grant is issued, so each ACK covers exactly one access.
  assign go_clear = (state == IDLE) && CLR_START;
  assign go_dbg   = (state == IDLE) && !CLR_START && DBG_REQ && !ack_q &&
                    (!CPU_WE || at_limit);

  // Starvation is counted only while the CPU's write is what blocks the
  // request. The count is held through a clear.
  assign starve_inc = (state == IDLE) && DBG_REQ && CPU_WE && !go_dbg;
  assign starve_clr = go_dbg || (!DBG_REQ && (state != CLEAR));

  dmem_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (Clock),
    .rst      (Reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      clr_addr   <= '0;
      ack_q      <= 1'b0;
      clr_done_q <= 1'b0;
      stall_q    <= 1'b0;
      gnt_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q      <= 1'b0;
      clr_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (go_clear) begin
            state   <= CLEAR;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (go_dbg) begin
            state   <= DBG;
            stall_q <= 1'b1;
            gnt_q   <= 1'b1;
          end
        end
        DBG: begin
          if (!DBG_WE) begin
            rdata_q <= DMEM_OUTPUT;
          end
          ack_q   <= 1'b1;
          state   <= IDLE;
          stall_q <= 1'b0;
          gnt_q   <= 1'b0;
        end
        CLEAR: begin
          // The increment wraps back to zero after the last word.
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            clr_done_q <= 1'b1;
            state      <= IDLE;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          stall_q <= 1'b0;
          gnt_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux, selected by the current owner.
  always_comb begin
    we_mux       = CPU_WE;
    WRITE_SELECT = CPU_WRITE_SELECT;
    READ_SELECT  = CPU_READ_SELECT;
    DMEM_INPUT   = CPU_DATA;
    case (state)
      DBG: begin
        we_mux       = DBG_WE;
        WRITE_SELECT = DBG_ADDR;
        READ_SELECT  = DBG_ADDR;
        DMEM_INPUT   = DBG_WDATA;
      end
      CLEAR: begin
        we_mux       = 1'b1;
        WRITE_SELECT = clr_addr;
        DMEM_INPUT   = CLEAR_VALUE;
      end
      default: ;
    endcase
  end

  // Reset is asynchronous. Gating the write strobe directly keeps the memory
  // untouched for the whole reset window, including the edge on which reset
  // is released.
  assign Write_Enable = we_mux && !Reset;

  assign CPU_STALL = stall_q;
  assign DBG_GNT   = gnt_q;
  assign DBG_ACK   = ack_q;
  assign DBG_RDATA = rdata_q;
  assign CLR_BUSY  = busy_q;
  assign CLR_DONE  = clr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_arbiter
// Description : Directed self-checking bench for dmem_access_arbiter. It
//               includes a 16x8 memory with a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CPU_WE;
  logic [3:0] CPU_WRITE_SELECT;
  logic [3:0] CPU_READ_SELECT;
  logic [7:0] CPU_DATA;
  logic       CPU_STALL;
  logic       DBG_REQ;
  logic       DBG_WE;
  logic [3:0] DBG_ADDR;
  logic [7:0] DBG_WDATA;
  logic       DBG_GNT;
  logic       DBG_ACK;
  logic [7:0] DBG_RDATA;
  logic       CLR_START;
  logic       CLR_BUSY;
  logic       CLR_DONE;
  logic       Write_Enable;
  logic [3:0] WRITE_SELECT;
  logic [3:0] READ_SELECT;
  logic [7:0] DMEM_INPUT;
  logic [7:0] DMEM_OUTPUT;

  logic [7:0] mem [16];

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Write_Enable) mem[WRITE_SELECT] <= DMEM_INPUT;
  end
  assign DMEM_OUTPUT = mem[READ_SELECT];

  dmem_access_arbiter dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .CPU_WE           (CPU_WE),
    .CPU_WRITE_SELECT (CPU_WRITE_SELECT),
    .CPU_READ_SELECT  (CPU_READ_SELECT),
    .CPU_DATA         (CPU_DATA),
    .CPU_STALL        (CPU_STALL),
    .DBG_REQ          (DBG_REQ),
    .DBG_WE           (DBG_WE),
    .DBG_ADDR         (DBG_ADDR),
    .DBG_WDATA        (DBG_WDATA),
    .DBG_GNT          (DBG_GNT),
    .DBG_ACK          (DBG_ACK),
    .DBG_RDATA        (DBG_RDATA),
    .CLR_START        (CLR_START),
    .CLR_BUSY         (CLR_BUSY),
    .CLR_DONE         (CLR_DONE),
    .Write_Enable     (Write_Enable),
    .WRITE_SELECT     (WRITE_SELECT),
    .READ_SELECT      (READ_SELECT),
    .DMEM_INPUT       (DMEM_INPUT),
    .DMEM_OUTPUT      (DMEM_OUTPUT)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    CPU_WE = 1'b1; CPU_WRITE_SELECT = 4'd3; CPU_READ_SELECT = 4'd0; CPU_DATA = 8'h5A;
    DBG_REQ = 1'b0; DBG_WE = 1'b0; DBG_ADDR = 4'd0; DBG_WDATA = 8'h00;
    CLR_START = 1'b0;

    // ---- 1: reset state, then CPU pass-through ----
    #12;
    check("rst_stall", CPU_STALL, 0);
    check("rst_gnt", DBG_GNT, 0);
    check("rst_ack", DBG_ACK, 0);
    check("rst_rdata", DBG_RDATA, 0);
    check("rst_busy", CLR_BUSY, 0);
    check("rst_done", CLR_DONE, 0);
    check("rst_we_forced0", Write_Enable, 0);
    Reset = 1'b0;
    #1;
    check("cpu_we", Write_Enable, 1);
    check("cpu_wsel", WRITE_SELECT, 3);
    check("cpu_din", DMEM_INPUT, 8'h5A);
    tick();
    CPU_WE = 1'b0; CPU_READ_SELECT = 4'd3;
    #1;
    check("cpu_rd3", DMEM_OUTPUT, 8'h5A);

    // ---- 2: debug write with the CPU idle ----
    DBG_REQ = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 4'd9; DBG_WDATA = 8'hC3;
    CPU_READ_SELECT = 4'd0;
    #1;
    check("t2_gnt_pre", DBG_GNT, 0);
    tick();
    check("t2_gnt", DBG_GNT, 1);
    check("t2_stall", CPU_STALL, 1);
    check("t2_we", Write_Enable, 1);
    check("t2_wsel", WRITE_SELECT, 9);
    check("t2_din", DMEM_INPUT, 8'hC3);
    tick();
    check("t2_ack", DBG_ACK, 1);
    check("t2_gnt_off", DBG_GNT, 0);
    check("t2_stall_off", CPU_STALL, 0);
    DBG_REQ = 1'b0;
    tick();
    check("t2_ack_off", DBG_ACK, 0);
    CPU_READ_SELECT = 4'd9;
    #1;
    check("t2_rd9", DMEM_OUTPUT, 8'hC3);

    // ---- 3: debug read starved by continuous CPU writes ----
    CPU_WE = 1'b1; CPU_WRITE_SELECT = 4'd2; CPU_DATA = 8'h77;
    tick();
    CPU_WRITE_SELECT = 4'd5; CPU_DATA = 8'h11;
    DBG_REQ = 1'b1; DBG_WE = 1'b0; DBG_ADDR = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_wait%0d", i), DBG_GNT, 0);
    end
    tick();
    check("t3_gnt", DBG_GNT, 1);
    check("t3_we_dbg_read", Write_Enable, 0);
    check("t3_rsel", READ_SELECT, 2);
    tick();
    check("t3_ack", DBG_ACK, 1);
    check("t3_rdata", DBG_RDATA, 8'h77);
    DBG_REQ = 1'b0; CPU_WE = 1'b0;
    tick();
    check("t3_rdata_hold", DBG_RDATA, 8'h77);

    // ---- 4: full clear ----
    CLR_START = 1'b1;
    tick();
    CLR_START = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("t4_busy%0d", k), CLR_BUSY, 1);
      check($sformatf("t4_stall%0d", k), CPU_STALL, 1);
      check($sformatf("t4_we%0d", k), Write_Enable, 1);
      check($sformatf("t4_wsel%0d", k), WRITE_SELECT, 16'(k));
      check($sformatf("t4_din%0d", k), DMEM_INPUT, 0);
      check($sformatf("t4_done_early%0d", k), CLR_DONE, 0);
      tick();
    end
    check("t4_done", CLR_DONE, 1);
    check("t4_busy_off", CLR_BUSY, 0);
    check("t4_stall_off", CPU_STALL, 0);
    tick();
    check("t4_done_pulse", CLR_DONE, 0);
    for (int a = 0; a < 16; a++) begin
      CPU_READ_SELECT = 4'(a);
      #1;
      check($sformatf("t4_rd%0d", a), DMEM_OUTPUT, 0);
    end

    // ---- 5: clear and debug request together ----
    CPU_WE = 1'b0;
    CLR_START = 1'b1;
    DBG_REQ = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 4'd4; DBG_WDATA = 8'hA5;
    tick();
    CLR_START = 1'b0;
    check("t5_busy", CLR_BUSY, 1);
    check("t5_gnt0", DBG_GNT, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("t5_gnt_wait%0d", i), DBG_GNT, 0);
    end
    tick();
    check("t5_done", CLR_DONE, 1);
    check("t5_gnt_at_done", DBG_GNT, 0);
    tick();
    check("t5_gnt", DBG_GNT, 1);
    check("t5_wsel", WRITE_SELECT, 4);
    tick();
    check("t5_ack", DBG_ACK, 1);
    DBG_REQ = 1'b0;
    tick();
    CPU_READ_SELECT = 4'd4;
    #1;
    check("t5_rd4", DMEM_OUTPUT, 8'hA5);

    // ---- 6: reset in the middle of a clear ----
    for (int a = 8; a < 16; a++) begin
      CPU_WE = 1'b1; CPU_WRITE_SELECT = 4'(a); CPU_DATA = 8'(8'h80 + a);
      tick();
    end
    CPU_WE = 1'b0;
    CLR_START = 1'b1;
    tick();
    CLR_START = 1'b0;
    repeat (7) tick();
    check("t6_wsel7", WRITE_SELECT, 7);
    Reset = 1'b1;
    #1;
    check("t6_busy_abort", CLR_BUSY, 0);
    check("t6_stall_abort", CPU_STALL, 0);
    check("t6_we_abort", Write_Enable, 0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_no_done%0d", i), CLR_DONE, 0);
      check($sformatf("t6_idle_busy%0d", i), CLR_BUSY, 0);
    end
    for (int a = 8; a < 16; a++) begin
      CPU_READ_SELECT = 4'(a);
      #1;
      check($sformatf("t6_keep%0d", a), DMEM_OUTPUT, 16'(8'h80 + a));
    end
    CPU_READ_SELECT = 4'd4;
    #1;
    check("t6_cleared4", DMEM_OUTPUT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
